// File: rtl/or_loop_pkg.sv
// ----------------------------------------------------------------------------
// or_loop_pkg
// Shared types and default timing constants for the OR-loop pulse sweeper.
//   sweep_state_t   : sequencer states
//   *_DEF constants : default clear/settle lengths and synchronizer depth
// ----------------------------------------------------------------------------
package or_loop_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_PULSE  = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_DONE   = 3'd5
  } sweep_state_t;

  localparam int CLEAR_CYC_DEF   = 16;
  localparam int SETTLE_CYC_DEF  = 32;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_ff.sv
// ----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer for a single asynchronous level signal.
//   clk, rst : destination clock, async active-high reset (flops reset to 0)
//   d        : asynchronous input
//   q        : input after STAGES flops in the clk domain
// ----------------------------------------------------------------------------
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at bit 0; the oldest sample leaves at the top.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/or_loop_pulse_sweeper.sv
// ----------------------------------------------------------------------------
// or_loop_pulse_sweeper
// Sweeps the pulse width applied to the buffered OR-feedback latch loop from
// width_min to width_max, clearing the loop before every trial and sampling
// the loop output after a settle window. Reports the first width that latched.
//   clk, rst             : system clock, async active-high reset
//   start, abort         : begin sweep (IDLE only) / cancel sweep
//   width_min, width_max : sweep bounds in cycles, captured on start
//   loop_out             : loop output, asynchronous to clk
//   pulse_out            : loop input drive
//   loop_clear           : breaks/clears loop feedback while high
//   busy, done           : sweep in progress / one-cycle end-of-sweep pulse
//   found, threshold     : a width latched the loop / that width
//   err                  : bad bounds or loop stuck high
//   trial_cnt            : trials executed in the current/last sweep
// ----------------------------------------------------------------------------
module or_loop_pulse_sweeper
  import or_loop_pkg::*;
#(
  parameter int W           = 8,
  parameter int CLEAR_CYC   = CLEAR_CYC_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] width_min,
  input  logic [W-1:0] width_max,
  input  logic         loop_out,
  output logic         pulse_out,
  output logic         loop_clear,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [W-1:0] threshold,
  output logic [W-1:0] trial_cnt
);

  // The shared phase counter must hold the longest of the three phases.
  localparam int CLR_W = $clog2(CLEAR_CYC + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (W > CLR_W) ? ((W > SET_W) ? W : SET_W)
                                     : ((CLR_W > SET_W) ? CLR_W : SET_W);
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYC - 1);

  sweep_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   cur_w_q, cur_w_d;
  logic [W-1:0]   wmax_q, wmax_d;
  logic [W-1:0]   threshold_q, threshold_d;
  logic [W-1:0]   trial_cnt_q, trial_cnt_d;
  logic           found_q, found_d;
  logic           err_q, err_d;
  logic           pulse_q, pulse_d;
  logic           clear_q, clear_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           lsync;

  sync_ff #(.STAGES(SYNC_STAGES)) u_loop_sync (
    .clk (clk),
    .rst (rst),
    .d   (loop_out),
    .q   (lsync)
  );

  // Next-state logic. Each phase loads cnt with (length-1) on entry and
  // leaves when it reaches zero. Abort bypasses every transition and leaves
  // the result registers untouched.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_w_d     = cur_w_q;
    wmax_d      = wmax_q;
    threshold_d = threshold_q;
    trial_cnt_d = trial_cnt_q;
    found_d     = found_q;
    err_d       = err_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            wmax_d      = width_max;
            found_d     = 1'b0;
            err_d       = 1'b0;
            threshold_d = '0;
            trial_cnt_d = '0;
            if ((width_min == '0) || (width_min > width_max)) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              cur_w_d = width_min;
              cnt_d   = CLR_LOAD;
              state_d = S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          if (cnt_q == '0) begin
            // Loop still high after a full clear means it is stuck.
            if (lsync) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              cnt_d       = CNT_W'(cur_w_q) - CNT_W'(1);
              trial_cnt_d = trial_cnt_q + W'(1);
              state_d     = S_PULSE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            cnt_d   = SET_LOAD;
            state_d = S_SETTLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          // Compare against wmax before incrementing so cur_w never wraps.
          if (lsync) begin
            found_d     = 1'b1;
            threshold_d = cur_w_q;
            state_d     = S_DONE;
          end else if (cur_w_q == wmax_q) begin
            found_d = 1'b0;
            state_d = S_DONE;
          end else begin
            cur_w_d = cur_w_q + W'(1);
            cnt_d   = CLR_LOAD;
            state_d = S_CLEAR;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Drive outputs follow the next state so they line up with it once
    // registered; done fires the cycle after DONE, together with busy falling.
    pulse_d = (state_d == S_PULSE);
    clear_d = (state_d == S_CLEAR);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_DONE) && !abort;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_w_q     <= '0;
      wmax_q      <= '0;
      threshold_q <= '0;
      trial_cnt_q <= '0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      pulse_q     <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_w_q     <= cur_w_d;
      wmax_q      <= wmax_d;
      threshold_q <= threshold_d;
      trial_cnt_q <= trial_cnt_d;
      found_q     <= found_d;
      err_q       <= err_d;
      pulse_q     <= pulse_d;
      clear_q     <= clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pulse_out  = pulse_q;
  assign loop_clear = clear_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign err        = err_q;
  assign threshold  = threshold_q;
  assign trial_cnt  = trial_cnt_q;

endmodule

// File: tb/tb_or_loop_pulse_sweeper.sv
// ----------------------------------------------------------------------------
// tb_or_loop_pulse_sweeper
// Drives the sweeper against a behavioural latch-loop model and compares
// every sweep result against a reference computed from the sweep rules.
// ----------------------------------------------------------------------------
module tb_or_loop_pulse_sweeper;

  localparam int W     = 8;
  localparam int CLR   = 16;
  localparam int SET   = 32;
  localparam int LIMIT = 20000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] width_min;
  logic [W-1:0] width_max;
  logic         loop_out = 1'b0;
  logic         pulse_out;
  logic         loop_clear;
  logic         busy;
  logic         done;
  logic         found;
  logic         err;
  logic [W-1:0] threshold;
  logic [W-1:0] trial_cnt;

  int nChecks = 0;
  int nPassed = 0;

  // Loop model: 0 = never latches, 1 = latches on a pulse of >= loopThr
  // cycles, 2 = stuck high.
  int loopMode = 0;
  int loopThr  = 5;
  int modelRun = 0;
  int pulseRun = 0;
  int clearRun = 0;
  int pulseRuns[$];
  int clearRuns[$];

  or_loop_pulse_sweeper #(
    .W(W), .CLEAR_CYC(CLR), .SETTLE_CYC(SET), .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .width_min  (width_min),
    .width_max  (width_max),
    .loop_out   (loop_out),
    .pulse_out  (pulse_out),
    .loop_clear (loop_clear),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .err        (err),
    .threshold  (threshold),
    .trial_cnt  (trial_cnt)
  );

  always #5 clk = ~clk;

  // Latch-loop model plus run-length recorder for pulse_out and loop_clear,
  // both evaluated on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (loopMode == 2) begin
      loop_out = 1'b1;
    end else if (loop_clear) begin
      loop_out = 1'b0;
      modelRun = 0;
    end else begin
      if (pulse_out) modelRun = modelRun + 1;
      else           modelRun = 0;
      if (loopMode == 1 && modelRun >= loopThr) loop_out = 1'b1;
    end

    if (pulse_out) pulseRun = pulseRun + 1;
    else if (pulseRun > 0) begin
      pulseRuns.push_back(pulseRun);
      pulseRun = 0;
    end
    if (loop_clear) clearRun = clearRun + 1;
    else if (clearRun > 0) begin
      clearRuns.push_back(clearRun);
      clearRun = 0;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int got, input int exp);
    nChecks++;
    if (got == exp) nPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Presents the bounds with start for exactly one rising edge; returns on
  // the falling edge right after start was sampled.
  task automatic applyStimulus(input int wmin, input int wmax);
    @(negedge clk);
    width_min = W'(wmin);
    width_max = W'(wmax);
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    width_min = W'($urandom);
    width_max = W'($urandom);
  endtask

  // Runs one full sweep and compares it with the result predicted from the
  // sweep rules: each trial tries the next width, stops at the first one the
  // loop latches on, and costs CLR + width + SET + 1 cycles.
  task automatic runSweep(input string tag, input int wmin, input int wmax,
                          input int mode, input int thr);
    int expTrials, expFound, expErr, expThr, expLat, expClears, cycles;
    loopMode = mode;
    loopThr  = thr;
    repeat (4) @(negedge clk);
    pulseRuns.delete();
    clearRuns.delete();

    expTrials = 0; expFound = 0; expErr = 0; expThr = 0;
    if (wmin == 0 || wmin > wmax) begin
      expErr = 1; expLat = 2; expClears = 0;
    end else if (mode == 2) begin
      expErr = 1; expLat = 2 + CLR; expClears = 1;
    end else begin
      expLat = 2;
      for (int w = wmin; w <= wmax; w++) begin
        expTrials++;
        expLat += CLR + w + SET + 1;
        if (mode == 1 && w >= thr) begin
          expFound = 1;
          expThr   = w;
          break;
        end
      end
      expClears = expTrials;
    end

    applyStimulus(wmin, wmax);
    checkOutput({tag, ".busy_start"}, busy, 1);
    cycles = 1;
    while (!done && cycles < LIMIT) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".latency"}, cycles, expLat);
    checkOutput({tag, ".busy_end"}, busy, 0);
    checkOutput({tag, ".found"}, found, expFound);
    checkOutput({tag, ".err"}, err, expErr);
    checkOutput({tag, ".threshold"}, threshold, expThr);
    checkOutput({tag, ".trial_cnt"}, trial_cnt, expTrials);
    checkOutput({tag, ".n_pulses"}, pulseRuns.size(), expTrials);
    foreach (pulseRuns[i]) checkOutput({tag, ".pulse_w"}, pulseRuns[i], wmin + i);
    checkOutput({tag, ".n_clears"}, clearRuns.size(), expClears);
    foreach (clearRuns[i]) checkOutput({tag, ".clear_w"}, clearRuns[i], CLR);
    @(negedge clk);
    checkOutput({tag, ".done_1cyc"}, done, 0);
    checkOutput({tag, ".result_hold"}, threshold, expThr);
  endtask

  initial begin
    int cycles, sawDone, wmin, wmax, mode;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    width_min = '0; width_max = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.pulse", pulse_out, 0);
    checkOutput("reset.clear", loop_clear, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.trial_cnt", trial_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    runSweep("latch5",   2, 10, 1, 5);
    runSweep("nolatch",  1, 3,  0, 5);
    runSweep("badorder", 7, 3,  1, 5);
    runSweep("zeromin",  0, 5,  1, 5);
    runSweep("stuck",    2, 10, 2, 5);
    loopMode = 0;
    runSweep("max255",   255, 255, 1, 5);

    // Abort in the middle of the second pulse; a start during trial 1 must
    // be ignored or trial 2 would never be reached.
    loopMode = 0;
    applyStimulus(2, 10);
    repeat (5) @(negedge clk);
    width_min = W'(1); width_max = W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!(trial_cnt == W'(2) && pulse_out) && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("abort.reach_trial2", int'(trial_cnt == W'(2) && pulse_out), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort.pulse", pulse_out, 0);
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.clear", loop_clear, 0);
    checkOutput("abort.done", done, 0);
    checkOutput("abort.found", found, 0);
    checkOutput("abort.err", err, 0);
    sawDone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("abort.no_done", sawDone, 0);
    runSweep("after_abort", 3, 6, 1, 4);

    // Randomized sweeps, including the occasional illegal bound pair.
    for (int n = 0; n < 8; n++) begin
      wmin = $urandom_range(0, 12);
      wmax = $urandom_range(0, 14);
      mode = ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1);
      runSweep($sformatf("rand%0d", n), wmin, wmax, mode, $urandom_range(1, 16));
      loopMode = 0;
    end

    // Asynchronous reset during SETTLE clears every output at once.
    loopMode = 1; loopThr = 3;
    repeat (4) @(negedge clk);
    applyStimulus(3, 3);
    cycles = 0;
    while (!pulse_out && cycles < LIMIT) begin @(negedge clk); cycles++; end
    while (pulse_out && cycles < LIMIT) begin @(negedge clk); cycles++; end
    repeat (5) @(negedge clk);
    checkOutput("rst_settle.busy_before", busy, 1);
    checkOutput("rst_settle.trial_before", trial_cnt, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_settle.busy", busy, 0);
    checkOutput("rst_settle.pulse", pulse_out, 0);
    checkOutput("rst_settle.clear", loop_clear, 0);
    checkOutput("rst_settle.done", done, 0);
    checkOutput("rst_settle.found", found, 0);
    checkOutput("rst_settle.err", err, 0);
    checkOutput("rst_settle.threshold", threshold, 0);
    checkOutput("rst_settle.trial_cnt", trial_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
